// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/serial_add_fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;
   logic g_ab;
   logic g_pc;

   assign p    = a ^ b;
   assign g_ab = a & b;
   assign s    = p ^ cin;
   assign g_pc = p & cin;
   assign cout = g_ab | g_pc;

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one result bit per clock, WIDTH clocks
// DONE  | one-cycle done pulse, outputs freshly loaded; start here chains the next operation
module serial_add
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic [WIDTH-2:0]   sum_q;
   logic [WIDTH-1:0]   sum_next;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   s_q;
   logic               cout_q;
   logic               ovf_q;
   logic               fa_s;
   logic               fa_cout;
   logic               load;
   logic               last;
   logic               c_msb;

   fa_cell u_fa (
      .a    (op_a_q[0]),
      .b    (op_b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   assign load     = start && ((state_q == IDLE) || (state_q == DONE));
   assign last     = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
   assign sum_next = {fa_s, sum_q};
   // On the last bit the carry register holds the carry into the MSB.
   assign c_msb    = carry_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_q  <= '0;
         op_b_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load) begin
         op_a_q  <= a;
         op_b_q  <= b ^ {WIDTH{sub}};
         carry_q <= sub ? ~cin : cin;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         op_a_q  <= op_a_q >> 1;
         op_b_q  <= op_b_q >> 1;
         sum_q   <= sum_next[WIDTH-1:1];
         carry_q <= fa_cout;
         if (last) begin
            s_q    <= sum_next;
            cout_q <= fa_cout;
            ovf_q  <= c_msb ^ fa_cout;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
         end
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add (WIDTH=8): fixed vectors, handshake/reset corners, random sweep.
module tb_serial_add;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int excl_viol = 0;
   int hold_viol = 0;
   bit mon_off = 1'b1;
   logic [W-1:0] s_prev;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
   } res_t;

   serial_add #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (busy && done) excl_viol++;
      if (!mon_off && !done && (s !== s_prev)) hold_viol++;
      s_prev = s;
   end

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic res_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mcin, logic msub);
      res_t r;
      int ua = ma;
      int ub = mb;
      int sa = $signed(ma);
      int sb = $signed(mb);
      int ci = mcin;
      int ur;
      int sr;
      if (!msub) begin
         ur = ua + ub + ci;
         sr = sa + sb + ci;
         r.cout = (ur > 255);
      end else begin
         ur = ua - ub - ci;
         sr = sa - sb - ci;
         r.cout = (ur >= 0);
      end
      r.s   = ur[W-1:0];
      r.ovf = (sr > 127) || (sr < -128);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Call at a negedge; returns at #1 after the start edge.
   task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb,
                         input logic lcin, input logic lsub, output int e0);
      a = la; b = lb; cin = lcin; sub = lsub; start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
   endtask

   // Returns at the negedge where done is high; lat = edges since the start edge.
   task automatic wait_done(input string name, input int e0, output int lat, output bit ok);
      ok = 1'b0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            lat = cyc - e0;
            break;
         end
      end
      if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         input logic rcin, input logic rsub, input res_t exp);
      int e0;
      int lat;
      bit ok;
      @(negedge clk);
      launch(ra, rb, rcin, rsub, e0);
      wait_done(name, e0, lat, ok);
      if (ok) begin
         chk({name, "_lat"},  lat,  W);
         chk({name, "_s"},    s,    exp.s);
         chk({name, "_cout"}, cout, exp.cout);
         chk({name, "_ovf"},  ovf,  exp.ovf);
      end
   endtask

   initial begin
      vec_t vecs[6];
      res_t r;
      int e0;
      int e1;
      int t1;
      int lat;
      int dn;
      bit ok;

      vecs[0] = '{a: 8'h5A, b: 8'h3C, cin: 1'b0, sub: 1'b0, s: 8'h96, cout: 1'b0, ovf: 1'b1};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h00, cout: 1'b1, ovf: 1'b0};
      vecs[2] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sub: 1'b0, s: 8'h00, cout: 1'b1, ovf: 1'b0};
      vecs[3] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sub: 1'b1, s: 8'hF0, cout: 1'b0, ovf: 1'b0};
      vecs[4] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, s: 8'h7F, cout: 1'b1, ovf: 1'b1};
      vecs[5] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sub: 1'b0, s: 8'h80, cout: 1'b0, ovf: 1'b1};

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_s",    s,    0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf",  ovf,  0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_off = 1'b0;

      foreach (vecs[i]) begin
         r = '{s: vecs[i].s, cout: vecs[i].cout, ovf: vecs[i].ovf};
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r);
      end

      // start pulsed mid-RUN with other operands must not disturb the running operation
      @(negedge clk);
      launch(8'h5A, 8'h3C, 1'b0, 1'b0, e0);
      repeat (3) @(negedge clk);
      a = 8'h11; b = 8'h22; sub = 1'b1; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign", e0, lat, ok);
      if (ok) begin
         chk("ign_lat", lat, W);
         chk("ign_s",   s,   8'h96);
         chk("ign_ovf", ovf, 1);
      end

      // back-to-back start in the DONE cycle
      @(negedge clk);
      launch(8'h01, 8'h02, 1'b0, 1'b0, e0);
      wait_done("b2b1", e0, lat, ok);
      t1 = cyc;
      if (ok) chk("b2b1_s", s, 8'h03);
      launch(8'h30, 8'h10, 1'b1, 1'b1, e1);
      chk("b2b_busy", busy, 1);
      wait_done("b2b2", e1, lat, ok);
      if (ok) begin
         chk("b2b_gap", cyc - t1, W + 1);
         chk("b2b2_s",  s,    8'h1F);
         chk("b2b2_cout", cout, 1);
      end

      // asynchronous reset in the 4th RUN cycle
      @(negedge clk);
      launch(8'h40, 8'h40, 1'b0, 1'b0, e0);
      repeat (3) @(posedge clk);
      mon_off = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_s",    s,    0);
      chk("arst_cout", cout, 0);
      chk("arst_ovf",  ovf,  0);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("arst_no_done", dn, 0);
      mon_off = 1'b0;
      run_op("after_rst", 8'h40, 8'h40, 1'b0, 1'b0, model(8'h40, 8'h40, 1'b0, 1'b0));

      for (int n = 0; n < 1000; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         logic         rs;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         run_op($sformatf("rnd%0d", n), ra, rb, rc, rs, model(ra, rb, rc, rs));
      end

      @(negedge clk);
      chk("busy_done_excl", excl_viol, 0);
      chk("s_hold",         hold_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
